spart_driver: RTL and testbench

Bus-master controller for the SPART serial port. It programs the baud divisor from the `br_cfg` switches after reset, and again whenever they change. It then runs a receive-to-transmit echo loop by sequencing single-cycle reads and writes on the SPART processor bus (`iocs`/`iorw`/`ioaddr`/`databus`). It sits between board switches and the SPART instance in the lab top level, and is the only master on that bus.

---
 rtl/spart_driver.sv | 161 ++++++++++++++++
 tb/tb_spart_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes every received byte.
// Define SPART_DRIVER_FIFO_EN for a 4-entry holding FIFO; otherwise a single holding byte is used.
module spart_driver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       cfg_done,
  output logic [7:0] last_rx
);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX_RD, RX_GAP, TX_WR} state_t;

  function automatic logic [15:0] calc_div(input logic [1:0] sel);
    int baud;
    case (sel)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    return 16'(CLK_HZ / (16 * baud) - 1);
  endfunction

  state_t      state;
  logic [1:0]  cfg_s1, cfg_sync, cur_cfg;
  logic [7:0]  dout;
  logic [15:0] div_lo, div_hi;
  logic        push, pop, st_empty, st_full;
  logic [7:0]  st_head;

  // No reset on the synchronizer so it tracks the switches while rst_n is held,
  // letting the very first CFG_LO write use the real setting.
  always_ff @(posedge clk) begin
    cfg_s1   <= br_cfg;
    cfg_sync <= cfg_s1;
  end

  assign div_lo  = calc_div(cfg_sync);
  assign div_hi  = calc_div(cur_cfg);
  assign databus = (iocs && !iorw) ? dout : 'z;

  // State names the access issued at this edge; RX_GAP is the edge closing the read cycle.
  assign push = (state == RX_GAP);
  assign pop  = (state == TX_WR);

`ifdef SPART_DRIVER_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 2'd1;
      count  <= count + 3'd1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 2'd1;
      count  <= count - 3'd1;
    end
  end

  assign st_empty = (count == 3'd0);
  assign st_full  = count[2];
  assign st_head  = mem[rd_ptr];
`else
  logic [7:0] hold;
  logic       hold_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (push) begin
      hold     <= databus;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign st_empty = !hold_vld;
  assign st_full  = hold_vld;
  assign st_head  = hold;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CFG_LO;
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= 2'b00;
      dout     <= '0;
      cfg_done <= 1'b0;
      last_rx  <= '0;
      cur_cfg  <= 2'b00;
    end else begin
      iocs <= 1'b0;
      iorw <= 1'b1;
      case (state)
        CFG_LO: begin
          iocs     <= 1'b1;
          iorw     <= 1'b0;
          ioaddr   <= 2'b10;
          dout     <= div_lo[7:0];
          cur_cfg  <= cfg_sync;
          cfg_done <= 1'b0;
          state    <= CFG_HI;
        end
        CFG_HI: begin
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b11;
          dout   <= div_hi[15:8];
          state  <= IDLE;
        end
        IDLE: begin
          if (cfg_sync != cur_cfg) begin
            state <= CFG_LO;
          end else begin
            cfg_done <= 1'b1;
            if (!st_empty && tbr)    state <= TX_WR;
            else if (rda && !st_full) state <= RX_RD;
          end
        end
        RX_RD: begin
          iocs   <= 1'b1;
          ioaddr <= 2'b00;
          state  <= RX_GAP;
        end
        RX_GAP: begin
          last_rx <= databus;
          state   <= IDLE;
        end
        TX_WR: begin
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b00;
          dout   <= st_head;
          state  <= IDLE;
        end
        default: state <= CFG_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a SPART bus model plus a scoreboard of expected accesses.
module tb_spart_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] last_rx;
  wire  [7:0] databus;
  logic [7:0] spart_rx = 8'h00;
  logic       tb_drv = 1'b0;

  int errors = 0;
  int checks = 0;
  int nreads = 0;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] src_q[$];

  spart_driver #(.CLK_HZ(50_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .cfg_done(cfg_done), .last_rx(last_rx)
  );

  // SPART answers reads; tb_drv puts 00 on the bus so a stray DUT drive shows up.
  assign databus = (iocs && iorw) ? spart_rx : (tb_drv ? 8'h00 : 8'hzz);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_acc(input logic rw, input logic [1:0] addr, input logic [7:0] data);
    acc_t a;
    a.rw = rw; a.addr = addr; a.data = data;
    exp_q.push_back(a);
  endtask

  task automatic expect_rd(input logic [7:0] d);
    expect_acc(1'b1, 2'b00, d);
  endtask

  task automatic expect_wr(input logic [7:0] d);
    expect_acc(1'b0, 2'b00, d);
  endtask

  task automatic offer(input logic [7:0] b);
    src_q.push_back(b);
    if (!rda) begin
      spart_rx = src_q[0];
      rda = 1'b1;
    end
  endtask

  // Bounded wait for the next access; a timeout counts as a failed check.
  task automatic wait_acc(input string tag, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!iocs && n < max);
    chk(tag, 32'(iocs), 32'd1);
  endtask

  // SPART model: consumes a byte per read, drops rda for the gap, then offers the next one.
  always @(negedge clk) begin
    if (iocs && iorw) begin
      void'(src_q.pop_front());
      rda = 1'b0;
    end else if (!rda && src_q.size() > 0) begin
      spart_rx = src_q[0];
      rda = 1'b1;
    end
  end

  // Scoreboard: every bus access must match the oldest expected access.
  always @(negedge clk) begin
    if (rst_n && iocs) begin
      if (iorw) nreads++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_access: got %0h want none", {iorw, ioaddr, databus});
      end
      if (exp_q.size() != 0) chk("access", 32'({iorw, ioaddr, databus}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0;
    logic prev_done;

    // Reset state with the synchronizer settling on br_cfg=01
    repeat (3) tick();
    chk("rst_iocs", 32'(iocs), 32'd0);
    chk("rst_iorw", 32'(iorw), 32'd1);
    chk("rst_ioaddr", 32'(ioaddr), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_last_rx", 32'(last_rx), 32'd0);

    // 50M / (16*9600) - 1 = 324 = 0x0144
    expect_acc(1'b0, 2'b10, 8'h44);
    expect_acc(1'b0, 2'b11, 8'h01);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("c1_iocs", 32'(iocs), 32'd1);
    chk("c1_addr", 32'(ioaddr), 32'd2);
    chk("c1_data", 32'(databus), 32'h44);
    tick();
    chk("c2_addr", 32'(ioaddr), 32'd3);
    chk("c2_cfg_done", 32'(cfg_done), 32'd0);
    tick();
    chk("c3_cfg_done", 32'(cfg_done), 32'd1);
    chk("c3_iocs", 32'(iocs), 32'd0);
    repeat (3) tick();

    // Reconfigure 01 -> 11: 50M / (16*38400) - 1 = 80 = 0x0050
    expect_acc(1'b0, 2'b10, 8'h50);
    expect_acc(1'b0, 2'b11, 8'h00);
    @(negedge clk) br_cfg = 2'b11;
    n = 0;
    prev_done = cfg_done;
    do begin
      prev_done = cfg_done;
      tick();
      n++;
    end while (!iocs && n < 12);
    chk("recfg_seen", 32'(iocs), 32'd1);
    chk("recfg_done_before", 32'(prev_done), 32'd1);
    chk("recfg_lo_done", 32'(cfg_done), 32'd0);
    tick();
    chk("recfg_hi_done", 32'(cfg_done), 32'd0);
    tick();
    chk("recfg_after_done", 32'(cfg_done), 32'd1);
    repeat (3) tick();

    // Echo of one byte: write follows the read by 3 cycles
    tbr = 1'b1;
    expect_rd(8'h41);
    expect_wr(8'h41);
    @(negedge clk) offer(8'h41);
    wait_acc("echo_read", 10, n);
    chk("echo_read_rw", 32'(iorw), 32'd1);
    tick();
    chk("echo_last_rx", 32'(last_rx), 32'h41);
    chk("echo_gap_iocs", 32'(iocs), 32'd0);
    tick();
    chk("echo_idle_iocs", 32'(iocs), 32'd0);
    tick();
    chk("echo_wr_iocs", 32'(iocs), 32'd1);
    chk("echo_wr_rw", 32'(iorw), 32'd0);
    chk("echo_wr_data", 32'(databus), 32'h41);
    repeat (4) tick();

    // Fill the holding store with the transmitter blocked
    @(negedge clk) tbr = 1'b0;
    r0 = nreads;
`ifdef SPART_DRIVER_FIFO_EN
    expect_rd(8'h61); expect_rd(8'h62); expect_rd(8'h63); expect_rd(8'h64);
`else
    expect_rd(8'h61);
`endif
    for (int i = 0; i < 5; i++) offer(8'h61 + 8'(i));
    repeat (40) tick();
`ifdef SPART_DRIVER_FIFO_EN
    chk("fill_reads", 32'(nreads - r0), 32'd4);
    chk("fill_last_rx", 32'(last_rx), 32'h64);
`else
    chk("fill_reads", 32'(nreads - r0), 32'd1);
    chk("fill_last_rx", 32'(last_rx), 32'h61);
`endif
    chk("fill_rda_pending", 32'(rda), 32'd1);
`ifdef SPART_DRIVER_FIFO_EN
    expect_wr(8'h61); expect_wr(8'h62); expect_wr(8'h63); expect_wr(8'h64);
    expect_rd(8'h65); expect_wr(8'h65);
`else
    expect_wr(8'h61);
    for (int i = 2; i <= 5; i++) begin
      expect_rd(8'h60 + 8'(i));
      expect_wr(8'h60 + 8'(i));
    end
`endif
    @(negedge clk) tbr = 1'b1;
    repeat (60) tick();
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_src_empty", 32'(src_q.size()), 32'd0);

    // Reset pulsed during a TX write
    @(negedge clk) tbr = 1'b0;
    expect_rd(8'h5a);
    offer(8'h5a);
    repeat (10) tick();
    chk("pre_rst_last_rx", 32'(last_rx), 32'h5a);
    @(negedge clk) tbr = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(iocs && !iorw) && n < 10);
    chk("rst_tx_seen", 32'(iocs && !iorw), 32'd1);
    chk("rst_tx_data", 32'(databus), 32'h5a);
    rst_n = 1'b0;
    tb_drv = 1'b1;
    #1;
    chk("rst_async_iocs", 32'(iocs), 32'd0);
    chk("rst_async_bus", 32'(databus), 32'h00);
    repeat (2) tick();
    chk("rst2_last_rx", 32'(last_rx), 32'd0);
    chk("rst2_cfg_done", 32'(cfg_done), 32'd0);
    expect_acc(1'b0, 2'b10, 8'h50);
    expect_acc(1'b0, 2'b11, 8'h00);
    @(negedge clk);
    tb_drv = 1'b0;
    rst_n = 1'b1;
    repeat (12) tick();
    chk("rst_no_stale_sb", 32'(exp_q.size()), 32'd0);
    chk("rst_cfg_done_back", 32'(cfg_done), 32'd1);

    // Reconfiguration and rda seen in the same IDLE cycle: config wins
    // 50M / (16*19200) - 1 = 161 = 0x00A1
    expect_acc(1'b0, 2'b10, 8'ha1);
    expect_acc(1'b0, 2'b11, 8'h00);
    expect_rd(8'h77);
    expect_wr(8'h77);
    @(negedge clk) br_cfg = 2'b10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) offer(8'h77);
    wait_acc("both_first", 10, n);
    chk("both_first_addr", 32'(ioaddr), 32'd2);
    repeat (20) tick();
    chk("both_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("both_last_rx", 32'(last_rx), 32'h77);
    chk("both_cfg_done", 32'(cfg_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
